// File: rtl/divider.sv
// Sequential restoring divider for DIV: LO = quotient, HI = remainder, one quotient bit per cycle.
// Optional unsigned mode (DivUnsigned port) when DIVIDER_DIVU_EN is defined.
module divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             DivReset_n,
  input  logic             DivCtrl,
`ifdef DIVIDER_DIVU_EN
  input  logic             DivUnsigned,
`endif
  input  logic [WIDTH-1:0] dividendo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             DivOUT,
  output logic             DivZero,
  output logic             DivBusy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dsr_q;
  logic             qsign_q;
  logic             rsign_q;

  logic             signed_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shift_d;
  logic [WIDTH:0]   trial_d;
  logic [WIDTH-1:0] rem_d;
  logic             qbit_d;
  logic [WIDTH-1:0] quo_fix_d;
  logic [WIDTH-1:0] rem_fix_d;

  always_comb begin
`ifdef DIVIDER_DIVU_EN
    signed_op = ~DivUnsigned;
`else
    signed_op = 1'b1;
`endif
    a_neg = signed_op & dividendo[WIDTH-1];
    b_neg = signed_op & divisor[WIDTH-1];
    a_mag = a_neg ? (~dividendo + 1'b1) : dividendo;
    b_mag = b_neg ? (~divisor + 1'b1) : divisor;
  end

  // |trial| < 2^WIDTH always, so WIDTH+1 signed bits hold it even for unsigned operands.
  always_comb begin
    shift_d   = {rem_q, quo_q[WIDTH-1]};
    trial_d   = shift_d - {1'b0, dsr_q};
    qbit_d    = ~trial_d[WIDTH];
    rem_d     = qbit_d ? trial_d[WIDTH-1:0] : shift_d[WIDTH-1:0];
    quo_fix_d = qsign_q ? (~quo_q + 1'b1) : quo_q;
    rem_fix_d = rsign_q ? (~rem_q + 1'b1) : rem_q;
  end

  always_ff @(posedge clk) begin
    if (!DivReset_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      HI      <= '0;
      LO      <= '0;
      DivOUT  <= 1'b0;
      DivZero <= 1'b0;
      DivBusy <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (DivCtrl) begin
            count_q <= '0;
            rem_q   <= '0;
            quo_q   <= a_mag;
            dsr_q   <= b_mag;
            qsign_q <= a_neg ^ b_neg;
            rsign_q <= a_neg;
            if (divisor == '0) begin
              HI      <= dividendo;
              LO      <= '1;
              DivZero <= 1'b1;
              DivOUT  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              DivBusy <= 1'b1;
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          rem_q   <= rem_d;
          quo_q   <= {quo_q[WIDTH-2:0], qbit_d};
          count_q <= count_q + 1'b1;
          if (count_q == CW'(WIDTH - 1)) state_q <= S_FIX;
        end
        S_FIX: begin
          HI      <= rem_fix_d;
          LO      <= quo_fix_d;
          DivOUT  <= 1'b1;
          DivZero <= 1'b0;
          DivBusy <= 1'b0;
          state_q <= S_DONE;
        end
        S_DONE: begin
          if (!DivCtrl) begin
            DivOUT  <= 1'b0;
            DivZero <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/divider.md
Name: divider

Overview:
- Sequential 32-bit signed restoring divider for the datapath's DIV instruction.
- Companion to the shift-add multiplier. It writes the same HI/LO pair: LO = quotient, HI = remainder.
- Driven by the control unit through a level handshake: DivCtrl is held high until DivOUT is returned.
- Busy for one cycle per quotient bit.

Parameters:
- WIDTH, 32, operand/result width; the counter is clog2(WIDTH)+1 bits.

Ports:
- clk  input  1  rising-edge clock
- DivReset_n  input  1  synchronous active-low reset
- DivCtrl  input  1  start request, level; held high by the control unit until DivOUT
- dividendo  input  WIDTH  dividend, two's complement; sampled on the capture edge only
- divisor  input  WIDTH  divisor, two's complement; sampled on the capture edge only
- HI  output  WIDTH  remainder
- LO  output  WIDTH  quotient
- DivOUT  output  1  done; high in DONE
- DivZero  output  1  divide-by-zero flag; valid while DivOUT=1
- DivBusy  output  1  high in CALC and FIX

Behaviour:
- Reset (DivReset_n=0 at a rising edge): HI=0, LO=0, DivOUT=0, DivZero=0, DivBusy=0, count=0, state IDLE. Reset overrides all other inputs in every state; an operation in flight is aborted with no result written.
- State IDLE, DivCtrl=1 at edge E0 (capture):
  - latch |dividendo|, |divisor|, sign of the quotient (XOR of operand signs), sign of the remainder (dividend sign);
  - clear the partial remainder; count=0.
  - divisor==0: go to DONE at E0 with HI=dividendo, LO=all ones, DivZero=1. DivOUT is high from E0+1, so the latency is 1.
  - otherwise: go to CALC.
- State CALC, one bit per edge (E1..E32):
  - shift {rem, quo} left by 1, bringing in the dividend MSB;
  - trial = rem - |divisor| in WIDTH+1 bits;
  - if trial is non-negative, rem=trial and quotient bit=1, else quotient bit=0;
  - count increments; after the edge with count==WIDTH-1 the state is FIX.
- State FIX (E33):
  - negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set;
  - write HI and LO; DivOUT=1, DivZero=0; go to DONE.
  - Latency is WIDTH+1 = 33 edges after E0.
- State DONE:
  - DivOUT=1; HI and LO are stable.
  - Stay while DivCtrl=1. When DivCtrl=0 is sampled, go to IDLE and clear DivOUT and DivZero at that edge.
  - A new operation therefore needs DivCtrl to drop for at least one cycle.
- DivCtrl is ignored in CALC and FIX; operand changes after E0 have no effect.
- HI and LO hold their last values until the next FIX, divide-by-zero capture, or reset.
- Arithmetic:
  - the quotient truncates toward zero; the remainder takes the dividend's sign; |HI| < |divisor|;
  - the magnitude of 0x80000000 is taken as unsigned 2^31;
  - 0x80000000 / -1 wraps: LO=0x80000000, HI=0, no flag.

Optional Feature:
- Macro DIVIDER_DIVU_EN.
- Defined: adds input port DivUnsigned (1 bit), sampled at E0. When it is 1, operands are treated as unsigned, sign fix-up is skipped, and divide-by-zero gives LO=all ones, HI=dividendo. When it is 0, behaviour is as above.
- Undefined: no port; always signed.

Test Plan:
- 100 / 7, DivCtrl held high -> DivBusy for 33 cycles; at E0+33 LO=14, HI=2, DivOUT=1. DivCtrl low -> DivOUT=0 at the next edge, HI/LO held.
- -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. 7 / -2 -> LO=0xFFFFFFFD, HI=1.
- 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, DivZero=0, latency 33.
- 5 / 0 -> DivOUT=1 and DivZero=1 one cycle after capture; LO=0xFFFFFFFF, HI=5. Next operation 12 / 4 -> DivZero=0, LO=3, HI=0.
- Reset mid-operation: DivReset_n=0 at E0+10 -> HI=LO=0, DivOUT=0, IDLE. The next 9 / 3 -> LO=3, HI=0 at 33-cycle latency. Operands changed after E0 -> no effect on the result.
- With DIVIDER_DIVU_EN defined, DivUnsigned=1: 0xFFFFFFFF / 2 -> LO=0x7FFFFFFF, HI=1. With DivUnsigned=0, the same operands -> LO=0, HI=0xFFFFFFFF.
